// File: rtl/pc_fetch_unit_if.sv
// pc_fetch_unit_if: fetch-stage bus bundle shared by the fetch unit and its environment.
// master = fetch unit (drives imem_addr, IF outputs, flushes, trap, counter)
// slave  = environment (drives EX redirect, stall, instruction memory data)
interface pc_fetch_unit_if #(parameter int CNT_W = 32);
  logic             jump_flag;
  logic [31:0]      jump_target;
  logic             stall;
  logic [31:0]      imem_addr;
  logic [31:0]      imem_rdata;
  logic [31:0]      if_pc;
  logic [31:0]      if_inst;
  logic             if_valid;
  logic             flush_if_id;
  logic             flush_id_ex;
  logic             trap_misaligned;
  logic [CNT_W-1:0] redirect_count;
  modport master (
    input  jump_flag, jump_target, stall, imem_rdata,
    output imem_addr, if_pc, if_inst, if_valid, flush_if_id, flush_id_ex,
           trap_misaligned, redirect_count
  );
  modport slave (
    output jump_flag, jump_target, stall, imem_rdata,
    input  imem_addr, if_pc, if_inst, if_valid, flush_if_id, flush_id_ex,
           trap_misaligned, redirect_count
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter and IF stage with EX redirect, stall, flush and trap.
// clk/rst: rising-edge clock, synchronous active-high reset.
// bus (master): EX redirect + stall in, imem address out / data in, IF outputs,
// IF/ID and ID/EX flushes, sticky misaligned-target trap, saturating redirect count.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input logic             clk,
  input logic             rst,
  pc_fetch_unit_if.master bus
);
  typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} state_t;
  state_t           state, state_d;
  logic [31:0]      pc_q, fetch_pc_q;
  logic             valid_q, trap_q;
  logic [CNT_W-1:0] cnt_q;
  logic             run, take, bad, hold, load;
  always_comb begin
    run = state == S_RUN;
    take = run & bus.jump_flag & (bus.jump_target[1:0] == 2'b00);
    bad = run & bus.jump_flag & (bus.jump_target[1:0] != 2'b00);
    hold = run & ~bus.jump_flag & bus.stall;
    load = (state == S_BOOT) | take | (run & ~bus.jump_flag & ~bus.stall);
    // redirect target bypasses straight to memory; stall and halt re-read the current fetch
    bus.imem_addr = take ? bus.jump_target : (hold | state == S_HALT) ? fetch_pc_q : pc_q;
    bus.flush_if_id = rst | (run & bus.jump_flag);
    bus.flush_id_ex = rst | (run & bus.jump_flag);
    bus.if_pc = fetch_pc_q;
    bus.if_inst = bus.imem_rdata;
    bus.if_valid = valid_q & run;
    bus.trap_misaligned = trap_q;
    bus.redirect_count = cnt_q;
    state_d = state == S_BOOT ? S_RUN : bad ? S_HALT : state;
  end
  always_ff @(posedge clk) begin
    if (rst) state <= S_BOOT;
    else state <= state_d;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
      fetch_pc_q <= '0;
      valid_q <= 1'b0;
      trap_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      if (load) begin
        fetch_pc_q <= bus.imem_addr;
        pc_q <= bus.imem_addr + 32'd4;
      end
      if ((state == S_BOOT) | take) valid_q <= 1'b1;
      if (bad) begin
        valid_q <= 1'b0;
        trap_q <= 1'b1;
      end
      if (take & ~&cnt_q) cnt_q <= cnt_q + 1'b1;
    end
  end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed vector table plus hand sequences for pc_fetch_unit.
module tb_pc_fetch_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  pc_fetch_unit_if #(.CNT_W(4)) bus ();
  pc_fetch_unit #(.RESET_PC(32'h100), .CNT_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction
  always @(posedge clk) bus.imem_rdata <= mem_f(bus.imem_addr);
  typedef struct {
    logic        rst, jf;
    logic [31:0] jt;
    logic        st;
    logic [31:0] addr, pc;
    logic        valid, flush, trap;
    logic [3:0]  cnt;
  } vec_t;
  vec_t tv[23];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  initial begin
    tv[0]  = '{1, 0, 32'h0,        0, 32'h100,      32'h0,        0, 1, 0, 0};
    tv[1]  = '{0, 0, 32'h0,        0, 32'h100,      32'h0,        0, 0, 0, 0};
    tv[2]  = '{0, 0, 32'h0,        0, 32'h104,      32'h100,      1, 0, 0, 0};
    tv[3]  = '{0, 0, 32'h0,        0, 32'h108,      32'h104,      1, 0, 0, 0};
    tv[4]  = '{0, 1, 32'h20C,      0, 32'h20C,      32'h108,      1, 1, 0, 0};
    tv[5]  = '{0, 1, 32'h40,       0, 32'h40,       32'h20C,      1, 1, 0, 1};
    tv[6]  = '{0, 0, 32'h0,        0, 32'h44,       32'h40,       1, 0, 0, 2};
    tv[7]  = '{0, 1, 32'h30,       0, 32'h30,       32'h44,       1, 1, 0, 2};
    tv[8]  = '{0, 0, 32'h0,        1, 32'h30,       32'h30,       1, 0, 0, 3};
    tv[9]  = '{0, 0, 32'h0,        1, 32'h30,       32'h30,       1, 0, 0, 3};
    tv[10] = '{0, 0, 32'h0,        1, 32'h30,       32'h30,       1, 0, 0, 3};
    tv[11] = '{0, 0, 32'h0,        0, 32'h34,       32'h30,       1, 0, 0, 3};
    tv[12] = '{0, 1, 32'h80,       1, 32'h80,       32'h34,       1, 1, 0, 3};
    tv[13] = '{0, 0, 32'h0,        0, 32'h84,       32'h80,       1, 0, 0, 4};
    tv[14] = '{0, 1, 32'hFFFFFFFC, 0, 32'hFFFFFFFC, 32'h84,       1, 1, 0, 4};
    tv[15] = '{0, 0, 32'h0,        0, 32'h0,        32'hFFFFFFFC, 1, 0, 0, 5};
    tv[16] = '{0, 0, 32'h0,        0, 32'h4,        32'h0,        1, 0, 0, 5};
    tv[17] = '{0, 1, 32'h82,       0, 32'h8,        32'h4,        1, 1, 0, 5};
    tv[18] = '{0, 1, 32'h100,      0, 32'h4,        32'h4,        0, 0, 1, 5};
    tv[19] = '{0, 0, 32'h0,        1, 32'h4,        32'h4,        0, 0, 1, 5};
    tv[20] = '{1, 0, 32'h0,        0, 32'h4,        32'h4,        0, 1, 1, 5};
    tv[21] = '{0, 1, 32'h200,      1, 32'h100,      32'h0,        0, 0, 0, 0};
    tv[22] = '{0, 0, 32'h0,        0, 32'h104,      32'h100,      1, 0, 0, 0};
    bus.jump_flag = 1'b0;
    bus.jump_target = '0;
    bus.stall = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      rst = tv[i].rst;
      bus.jump_flag = tv[i].jf;
      bus.jump_target = tv[i].jt;
      bus.stall = tv[i].st;
      #1;
      chk($sformatf("v%0d imem_addr", i), bus.imem_addr, tv[i].addr);
      chk($sformatf("v%0d if_pc", i), bus.if_pc, tv[i].pc);
      chk($sformatf("v%0d if_valid", i), {31'b0, bus.if_valid}, {31'b0, tv[i].valid});
      chk($sformatf("v%0d flush_if_id", i), {31'b0, bus.flush_if_id}, {31'b0, tv[i].flush});
      chk($sformatf("v%0d flush_id_ex", i), {31'b0, bus.flush_id_ex}, {31'b0, tv[i].flush});
      chk($sformatf("v%0d trap", i), {31'b0, bus.trap_misaligned}, {31'b0, tv[i].trap});
      chk($sformatf("v%0d count", i), {28'b0, bus.redirect_count}, {28'b0, tv[i].cnt});
      if (tv[i].valid) chk($sformatf("v%0d if_inst", i), bus.if_inst, mem_f(tv[i].pc));
    end
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      bus.jump_flag = 1'b1;
      bus.jump_target = 32'h1000 + 32'(i) * 32'h10;
      #1;
      chk($sformatf("sat%0d imem_addr", i), bus.imem_addr, 32'h1000 + 32'(i) * 32'h10);
      chk($sformatf("sat%0d count", i), {28'b0, bus.redirect_count}, (i > 15) ? 32'd15 : 32'(i));
    end
    @(negedge clk);
    bus.jump_flag = 1'b0;
    #1;
    chk("sat final count", {28'b0, bus.redirect_count}, 32'd15);
    chk("sat final if_pc", bus.if_pc, 32'h1100);
    chk("sat final imem_addr", bus.imem_addr, 32'h1104);
    chk("sat final if_inst", bus.if_inst, mem_f(32'h1100));
    @(negedge clk);
    rst = 1'b1;
    bus.jump_flag = 1'b1;
    bus.jump_target = 32'h2000;
    #1;
    chk("midrst flush", {31'b0, bus.flush_id_ex}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    bus.jump_flag = 1'b0;
    #1;
    chk("midrst imem_addr", bus.imem_addr, 32'h100);
    chk("midrst count", {28'b0, bus.redirect_count}, 32'd0);
    chk("midrst if_valid", {31'b0, bus.if_valid}, 32'd0);
    @(negedge clk);
    #1;
    chk("midrst if_pc", bus.if_pc, 32'h100);
    chk("midrst if_valid rise", {31'b0, bus.if_valid}, 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
